// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer for the Execute stage
// Define MULDIV_SEQ_FAST_MUL_EN for single-cycle MUL-family ops; division stays iterative.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CntLast = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} seqState;

    seqState           state;
    logic [CW-1:0]     cnt;
    logic [2:0]        opReg;
    logic              aNegReg;
    logic              bNegReg;
    logic [XLEN-1:0]   bAbsReg;
    logic [2*XLEN-1:0] prodReg;
    logic [XLEN-1:0]   remReg;
    logic [XLEN-1:0]   quoReg;

    logic              aSigned;
    logic              bSigned;
    logic              aNeg;
    logic              bNeg;
    logic [XLEN-1:0]   aAbs;
    logic [XLEN-1:0]   bAbs;
    logic              divByZero;
    logic              divOverflow;
    logic [XLEN-1:0]   earlyResult;
    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     divShift;
    logic [XLEN:0]     divDiff;
    logic [2*XLEN-1:0] prodFinal;
    logic [XLEN-1:0]   quoFinal;
    logic [XLEN-1:0]   remFinal;
    logic [XLEN-1:0]   fixupResult;

    // MULH, MULHSU (a only), DIV and REM treat their operands as signed.
    assign aSigned = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                     (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign bSigned = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                     (funct3_i == 3'b110);
    assign aNeg    = aSigned && a_i[XLEN-1];
    assign bNeg    = bSigned && b_i[XLEN-1];
    assign aAbs    = aNeg ? -a_i : a_i;
    assign bAbs    = bNeg ? -b_i : b_i;

    assign divByZero   = (b_i == '0);
    assign divOverflow = !funct3_i[0] && (a_i == MinNeg) && (b_i == AllOnes);
    assign earlyResult = divByZero ? (funct3_i[1] ? a_i : AllOnes)
                                   : (funct3_i[1] ? '0 : MinNeg);

`ifdef MULDIV_SEQ_FAST_MUL_EN
    logic [2*XLEN-1:0] aExt;
    logic [2*XLEN-1:0] bExt;
    logic [2*XLEN-1:0] fastProd;

    // Low 2*XLEN bits of the sign-extended product are exact for every MUL variant.
    assign aExt     = {{XLEN{aNeg}}, a_i};
    assign bExt     = {{XLEN{bNeg}}, b_i};
    assign fastProd = aExt * bExt;
`endif

    assign mulSum   = {1'b0, prodReg[2*XLEN-1:XLEN]} + (prodReg[0] ? {1'b0, bAbsReg} : '0);
    assign divShift = {remReg, quoReg[XLEN-1]};
    assign divDiff  = divShift - {1'b0, bAbsReg};

    assign prodFinal = (aNegReg ^ bNegReg) ? -prodReg : prodReg;
    assign quoFinal  = (aNegReg ^ bNegReg) ? -quoReg : quoReg;
    assign remFinal  = aNegReg ? -remReg : remReg;

    always_comb begin
        fixupResult = '0;
        case (opReg)
            3'b000:                 fixupResult = prodFinal[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fixupResult = prodFinal[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fixupResult = quoFinal;
            default:                fixupResult = remFinal;
        endcase
    end

    assign stall_o = ((state == IDLE) && start_i && !flush_i) ||
                     (state == MUL) || (state == DIV) || (state == FIXUP);
    assign busy_o  = (state != IDLE);
    assign done_o  = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            opReg    <= '0;
            aNegReg  <= 1'b0;
            bNegReg  <= 1'b0;
            bAbsReg  <= '0;
            prodReg  <= '0;
            remReg   <= '0;
            quoReg   <= '0;
            result_o <= '0;
        end else if (flush_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        opReg   <= funct3_i;
                        aNegReg <= aNeg;
                        bNegReg <= bNeg;
                        bAbsReg <= bAbs;
                        cnt     <= '0;
                        if (funct3_i[2]) begin
                            if (divByZero || divOverflow) begin
                                result_o <= earlyResult;
                                state    <= DONE;
                            end else begin
                                remReg <= '0;
                                quoReg <= aAbs;
                                state  <= DIV;
                            end
                        end else begin
`ifdef MULDIV_SEQ_FAST_MUL_EN
                            result_o <= (funct3_i[1:0] == 2'b00) ? fastProd[XLEN-1:0]
                                                                 : fastProd[2*XLEN-1:XLEN];
                            state    <= DONE;
`else
                            prodReg <= {{XLEN{1'b0}}, aAbs};
                            state   <= MUL;
`endif
                        end
                    end
                end
                MUL: begin
                    // Multiplier bits are consumed from the low half as the product shifts right.
                    prodReg <= {mulSum, prodReg[XLEN-1:1]};
                    cnt     <= cnt + CW'(1);
                    if (cnt == CntLast) begin
                        state <= FIXUP;
                    end
                end
                DIV: begin
                    remReg <= divDiff[XLEN] ? divShift[XLEN-1:0] : divDiff[XLEN-1:0];
                    quoReg <= {quoReg[XLEN-2:0], ~divDiff[XLEN]};
                    cnt    <= cnt + CW'(1);
                    if (cnt == CntLast) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    result_o <= fixupResult;
                    cnt      <= '0;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer in the Execute stage of the 5-stage pipeline.
- Accepts R-type ops with funct7=0000001, i.e. the ops for which the main decoder selects ResultSrc=100.
- Runs a radix-2 shift-add multiply or restoring divide over XLEN cycles and stalls the pipeline until the result is ready.
- The hazard unit ORs stall_o into StallF/StallD/StallE; the result enters the E→M register on the done cycle.

Parameters:
- XLEN, 32, operand/result width; internal iteration counter is $clog2(XLEN) bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  M-extension op valid in Execute
- flush_i  in  1  Execute flush (branch/jump kill)
- funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a_i  in  XLEN  rs1 operand (post-forwarding)
- b_i  in  XLEN  rs2 operand (post-forwarding)
- stall_o  out  1  pipeline stall request
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse; result_o valid
- result_o  out  XLEN  result

Behaviour:
- Reset: clk edge with rst_n=0 → state IDLE, counter 0, result_o 0, done_o 0, busy_o 0. Internal accumulator, quotient and remainder registers are cleared. Reset mid-operation aborts with no done_o.
- States: IDLE, MUL, DIV, FIXUP, DONE.
- IDLE, start_i=1, flush_i=0: latch funct3, operand signs and absolute values, according to the signedness of funct3.
  - DIV/REM signed; DIVU/REMU unsigned.
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU/MUL: unsigned path, with MUL taking the low word.
  - Next state is MUL (funct3[2]=0) or DIV (funct3[2]=1), counter 0.
- Early-out cases in IDLE go directly to DONE:
  - Divide by zero (b_i=0): quotient = all ones, remainder = a_i, for signed and unsigned.
  - Signed overflow (a_i=0x80000000, b_i=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- MUL: one shift-add step per cycle over a 2*XLEN product register. DIV: one restoring shift-subtract step per cycle. Counter increments each cycle; at counter=XLEN-1 the next state is FIXUP.
- FIXUP:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ (DIV).
  - Give the remainder the sign of the dividend (REM).
  - Select the low word (MUL), the high word (MULH*), the quotient or the remainder.
  - Register into result_o. Next state DONE.
- DONE: done_o=1, stall_o=0, so the pipeline advances with result_o. start_i is ignored. Next state IDLE.
- Latency, with start_i sampled in cycle 0:
  - Iterative: MUL/DIV in cycles 1..XLEN, FIXUP in XLEN+1, done_o in cycle XLEN+2 (34 for XLEN=32).
  - Early-out: done_o in cycle 1.
- stall_o = (IDLE & start_i & ~flush_i) | MUL | DIV | FIXUP. It is combinational so the issuing instruction is held from cycle 0.
- flush_i=1 in any state: next state IDLE, done_o not asserted, result_o unchanged. flush_i has priority over start_i.
- result_o holds its value from DONE until the next FIXUP or early-out write.
- Operands are latched only in IDLE. Changes on a_i/b_i after acceptance have no effect.

Optional Feature:
- Macro MULDIV_SEQ_FAST_MUL_EN.
- When defined: MUL-family ops are computed in IDLE with a single-cycle 2*XLEN combinational multiply (signed-extended per funct3), then go IDLE→DONE with done_o in cycle 1. The MUL state is unreachable.
- When undefined: the iterative XLEN+2-cycle path. Division is iterative in both builds.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (−3) → result 0xFFFFFFEB; done_o in cycle 34 (cycle 1 with FAST_MUL_EN); stall_o high in cycles 0–33, low in 34.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each with done_o in cycle 34.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0; each with done_o in cycle 1.
- DIV started, flush_i=1 in cycle 10 → IDLE in cycle 11; no done_o; result_o keeps its prior value; a new start in cycle 12 completes normally.
- MUL started, rst_n=0 in cycle 5 → IDLE; result_o=0; busy_o=0; stall_o=0 next cycle; no done_o.
